// File: rtl/dsr_pkg.sv
// Shared constants and helpers for the dynamic shift register family.
package dsr_pkg;

    localparam int unsigned DSR_MAX_DEPTH = 1024;

    // Ceiling log2 with a floor of 1, so that a 2-deep line still gets a 1-bit select.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dsr_fill_ctr.sv
// Fill counter: how many samples have been written since the last reset or clear.
module dsr_fill_ctr #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned FILLW = 6
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic             CLR,
    output logic [FILLW-1:0] FILL
);

    localparam logic [FILLW-1:0] FULL = FILLW'(DEPTH);

    // A clear coinciding with a shift still counts the sample entering this cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            FILL <= '0;
        end else if (CLR) begin
            FILL <= CE ? FILLW'(1) : '0;
        end else if (CE && (FILL != FULL)) begin
            FILL <= FILL + 1'b1;
        end
    end

endmodule

// File: rtl/dynamic_shift_register_multi.sv
// Variable-tap delay line with fill tracking, select range check and optional output register.
module dynamic_shift_register_multi
    import dsr_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned SELWIDTH = 5,
    parameter int unsigned OUTREG   = 0
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                CE,
    input  logic                CLR,
    input  logic [SELWIDTH-1:0] SEL,
    input  logic [WIDTH-1:0]    SI,
    output logic [WIDTH-1:0]    DO,
    output logic                DO_VALID,
    output logic                SEL_ERR,
    output logic [SELWIDTH:0]   FILL
);

    localparam int unsigned FILLW = SELWIDTH + 1;

    if ((SELWIDTH != clog2(DEPTH)) || (DEPTH < 2) || (DEPTH > DSR_MAX_DEPTH)) begin : g_bad_param
        $error("dynamic_shift_register_multi: need 2<=DEPTH<=1024 and SELWIDTH==clog2(DEPTH)");
    end

    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;
    logic             tap_err;

    // No reset on the array so it can map onto shift-register primitives.
    always_ff @(posedge CLK) begin
        if (CE) begin
            data[0] <= SI;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    dsr_fill_ctr #(
        .DEPTH (DEPTH),
        .FILLW (FILLW)
    ) u_fill_ctr (
        .CLK  (CLK),
        .RSTN (RSTN),
        .CE   (CE),
        .CLR  (CLR),
        .FILL (FILL)
    );

    always_comb begin
        tap_err   = (32'(SEL) >= DEPTH);
        tap_valid = !tap_err && (FILLW'(SEL) < FILL);
        tap_data  = tap_valid ? data[SEL] : '0;
    end

    if (OUTREG != 0) begin : g_outreg
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                DO       <= '0;
                DO_VALID <= 1'b0;
                SEL_ERR  <= 1'b0;
            end else begin
                DO       <= tap_data;
                DO_VALID <= tap_valid;
                SEL_ERR  <= tap_err;
            end
        end
    end else begin : g_comb
        assign DO       = tap_data;
        assign DO_VALID = tap_valid;
        assign SEL_ERR  = tap_err;
    end

endmodule
